// File: rtl/gfx256_pkg.sv
// Shared types and constants for the 256-bit wide line reader.
// Holds the FSM state encoding, the beat count and Wishbone CTI codes.
package gfx256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    FETCH,
    DONE,
    WAITLOW
  } state_e;

  localparam int BEATS = 8;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

endpackage

// File: rtl/gfx256_wide_reader.sv
// Reads a 256-bit line over a 32-bit Wishbone burst.
// A one-line buffer short-circuits repeated full-line reads.
module gfx256_wide_reader
  import gfx256_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic [31:0]  sel_i,
  input  logic [31:0]  adr_i,
  output logic [255:0] dat_o,
  output logic         ack_o,
  output logic         err_o,
  input  logic         inv_i,
  output logic         m_cyc_o,
  output logic         m_stb_o,
  output logic         m_we_o,
  output logic [2:0]   m_cti_o,
  output logic [3:0]   m_sel_o,
  output logic [31:0]  m_adr_o,
  input  logic [31:0]  m_dat_i,
  input  logic         m_ack_i,
  input  logic         m_err_i
);

  state_e         state_q, state_d;
  logic [26:0]    adr_q, adr_d;
  logic [31:0]    sel_q, sel_d;
  logic [2:0]     beat_q, beat_d;
  logic [255:0]   dat_q, dat_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           hit;
  logic           last;
  logic [31:0]    lane;

  // Buffered line matches the incoming request.
  assign hit  = CACHE_EN && valid_q
                && (adr_q == adr_i[31:5]);
  assign last = (beat_q == 3'(BEATS - 1));
  assign lane = (sel_q[{beat_q, 2'b00} +: 4] != 4'h0)
                ? m_dat_i : 32'h0;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i) state_d = hit ? HIT : FETCH;
      HIT:     state_d = WAITLOW;
      FETCH: begin
        if (m_err_i)              state_d = DONE;
        else if (m_ack_i && last) state_d = DONE;
      end
      DONE:    state_d = WAITLOW;
      WAITLOW: if (!req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    ack_o   = (state_q == HIT) || (state_q == DONE);
    err_o   = (state_q == DONE) && err_q;
    m_cyc_o = (state_q == FETCH);
    m_stb_o = (state_q == FETCH);
    m_we_o  = 1'b0;
    m_cti_o = 3'b000;
    m_sel_o = 4'h0;
    m_adr_o = 32'h0;
    if (state_q == FETCH) begin
      m_cti_o = last ? CTI_EOB : CTI_INCR;
      m_sel_o = sel_q[{beat_q, 2'b00} +: 4];
      m_adr_o = {adr_q, beat_q, 2'b00};
    end
    dat_o = dat_q;
  end

  // Request latch, beat counter, line fill and valid tracking.
  always_comb begin
    adr_d   = adr_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    dat_d   = dat_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          adr_d  = adr_i[31:5];
          sel_d  = sel_i;
          beat_d = 3'd0;
          err_d  = 1'b0;
          // A miss overwrites the buffer, so it is no longer trustworthy.
          if (!hit) valid_d = 1'b0;
        end
      end
      FETCH: begin
        if (m_err_i) begin
          for (int i = 0; i < BEATS; i++) begin
            if (i >= int'(beat_q)) dat_d[i*32 +: 32] = 32'h0;
          end
          err_d   = 1'b1;
          valid_d = 1'b0;
          beat_d  = 3'd0;
        end else if (m_ack_i) begin
          dat_d[{beat_q, 5'b00000} +: 32] = lane;
          beat_d = beat_q + 3'd1;
          if (last) valid_d = &sel_q;
        end
      end
      default: ;
    endcase
    if (inv_i) valid_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q   <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
      dat_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gfx256_wide_reader.sv
// Scoreboard bench for gfx256_wide_reader.
// Directed requests against a zero-wait Wishbone slave model.
module tb_gfx256_wide_reader;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_i;
  logic [31:0]  sel_i;
  logic [31:0]  adr_i;
  logic [255:0] dat_o;
  logic         ack_o;
  logic         err_o;
  logic         inv_i;
  logic         m_cyc_o;
  logic         m_stb_o;
  logic         m_we_o;
  logic [2:0]   m_cti_o;
  logic [3:0]   m_sel_o;
  logic [31:0]  m_adr_o;
  logic [31:0]  m_dat_i;
  logic         m_ack_i;
  logic         m_err_i;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  err_beat = -1;
  bit  inv_arm = 1'b0;

  logic [256:0] exp_q[$];
  logic [31:0]  adr_log[$];
  logic [2:0]   cti_log[$];
  logic [3:0]   sel_log[$];

  gfx256_wide_reader #(.CACHE_EN(1'b1)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .sel_i   (sel_i),
    .adr_i   (adr_i),
    .dat_o   (dat_o),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .inv_i   (inv_i),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_cti_o (m_cti_o),
    .m_sel_o (m_sel_o),
    .m_adr_o (m_adr_o),
    .m_dat_i (m_dat_i),
    .m_ack_i (m_ack_i),
    .m_err_i (m_err_i)
  );

  always #5 clk = ~clk;

  assign m_err_i = m_cyc_o && m_stb_o
                   && (err_beat == int'(m_adr_o[4:2]));
  assign m_ack_i = m_cyc_o && m_stb_o && !m_err_i;
  assign m_dat_i = 32'hA000_0000 + {29'd0, m_adr_o[4:2]};

  always @(negedge clk)
    inv_i = inv_arm && m_cyc_o && (m_adr_o[4:2] == 3'd7);

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Beat logger.
  always @(negedge clk) begin
    if (m_cyc_o && m_stb_o && (m_ack_i || m_err_i)) begin
      adr_log.push_back(m_adr_o);
      cti_log.push_back(m_cti_o);
      sel_log.push_back(m_sel_o);
    end
  end

  // Monitor: pops an expectation on each ack_o.
  always @(negedge clk) begin
    if (!rst_i && ack_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 256'(ack_o), 256'(0));
      end else begin
        logic [256:0] e;
        e = exp_q.pop_front();
        chk("ack_dat", dat_o, e[255:0]);
        chk("ack_err", 256'(err_o), 256'(e[256]));
      end
    end
  end

  task automatic do_req(input string nm,
                        input logic [31:0] adr,
                        input logic [31:0] sel,
                        input logic [255:0] edat,
                        input logic eerr,
                        input int lat,
                        input int beats,
                        input int hold);
    int  n;
    bit  got;
    adr_log.delete();
    cti_log.delete();
    sel_log.delete();
    exp_q.push_back({eerr, edat});
    @(posedge clk);
    #1;
    req_i = 1'b1;
    adr_i = adr;
    sel_i = sel;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        adr_i = 32'hDEAD_BEE0;
        sel_i = 32'h0;
      end
      if (ack_o) got = 1'b1;
    end
    if (!got) chk({nm, "_timeout"}, 256'(0), 256'(1));
    else      chk({nm, "_latency"}, 256'(n), 256'(lat));
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_beats"}, 256'(adr_log.size()), 256'(beats));
  endtask

  localparam logic [255:0] D_FULL = {
    32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004,
    32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  localparam logic [255:0] D_PART = {
    32'h0, 32'h0, 32'h0, 32'h0,
    32'hA000_0003, 32'hA000_0002, 32'h0, 32'hA000_0000};
  localparam logic [255:0] D_ERR = {
    32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  initial begin
    int n;
    rst_i = 1'b1;
    req_i = 1'b0;
    sel_i = 32'h0;
    adr_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack",  256'(ack_o),   256'(0));
    chk("rst_err",  256'(err_o),   256'(0));
    chk("rst_cyc",  256'(m_cyc_o), 256'(0));
    chk("rst_adr",  256'(m_adr_o), 256'(0));
    chk("rst_dat",  dat_o,         256'(0));
    rst_i = 1'b0;

    do_req("miss", 32'h0000_1040, ONES, D_FULL, 1'b0, 10, 8, 0);
    if (adr_log.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("miss_adr", 256'(adr_log[k]), 256'(32'h1040 + 4 * k));
        chk("miss_cti", 256'(cti_log[k]),
            256'((k == 7) ? 3'b111 : 3'b010));
      end
    end

    do_req("hit", 32'h0000_1040, ONES, D_FULL, 1'b0, 2, 0, 0);

    do_req("part", 32'h0000_2000, 32'h0000_FF0F, D_PART, 1'b0, 10, 8, 0);
    if (sel_log.size() == 8) begin
      chk("part_sel0", 256'(sel_log[0]), 256'(4'hF));
      chk("part_sel1", 256'(sel_log[1]), 256'(4'h0));
    end
    do_req("part_re", 32'h0000_2000, 32'h0000_FF0F, D_PART, 1'b0, 10, 8, 0);

    err_beat = 3;
    do_req("err", 32'h0000_3000, ONES, D_ERR, 1'b1, 6, 4, 0);
    err_beat = -1;
    chk("err_cyc_low", 256'(m_cyc_o), 256'(0));
    do_req("err_re", 32'h0000_3000, ONES, D_FULL, 1'b0, 10, 8, 0);
    do_req("err_hit", 32'h0000_3000, ONES, D_FULL, 1'b0, 2, 0, 0);

    inv_arm = 1'b1;
    do_req("inv", 32'h0000_4000, ONES, D_FULL, 1'b0, 10, 8, 0);
    inv_arm = 1'b0;
    do_req("inv_re", 32'h0000_4000, ONES, D_FULL, 1'b0, 10, 8, 0);

    do_req("hold", 32'h0000_5000, ONES, D_FULL, 1'b0, 10, 8, 5);
    do_req("hold_hit", 32'h0000_5000, ONES, D_FULL, 1'b0, 2, 0, 0);

    exp_q.push_back({1'b0, D_FULL});
    @(posedge clk);
    #1;
    req_i = 1'b1;
    adr_i = 32'h0000_6000;
    sel_i = ONES;
    n = 0;
    while (n < 40 && !(m_cyc_o && m_adr_o[4:2] == 3'd4)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("rst_mid_timeout", 256'(0), 256'(1));
    rst_i = 1'b1;
    #1;
    chk("rst_mid_cyc", 256'(m_cyc_o), 256'(0));
    chk("rst_mid_ack", 256'(ack_o), 256'(0));
    exp_q.delete();
    req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    do_req("post_rst", 32'h0000_6000, ONES, D_FULL, 1'b0, 10, 8, 0);
    do_req("rst_clr_valid", 32'h0000_5000, ONES, D_FULL, 1'b0, 10, 8, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gfx256_wide_reader.md
GFX256_WIDE_READER -- requirements
Module: gfx256_wide_reader

Interface
REQ-001 SHALL have parameter CACHE_EN, default 1, which enables the one-line read buffer (0 = always fetch).
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with ports as listed:
  clk_i  in  1  sole clock, rising edge
  rst_i  in  1  asynchronous reset, active-high
  req_i  in  1  read request from the blitter; held high until ack_o is seen, then dropped
  sel_i  in  32  byte enables for the 256-bit line
  adr_i  in  32  line address; bits [4:0] ignored
  dat_o  out  256  returned line
  ack_o  out  1  one-cycle completion pulse; dat_o valid in that cycle
  err_o  out  1  pulses with ack_o when the bus reported an error
  inv_i  in  1  invalidate the buffered line
  m_cyc_o  out  1  Wishbone cycle
  m_stb_o  out  1  Wishbone strobe
  m_we_o  out  1  always 0
  m_cti_o  out  3  cycle type: 3'b010 burst, 3'b111 last beat
  m_sel_o  out  4  per-beat byte enables
  m_adr_o  out  32  beat address
  m_dat_i  in  32  beat read data
  m_ack_i  in  1  beat acknowledge
  m_err_i  in  1  beat error

Function
REQ-003 SHALL use states IDLE, HIT, FETCH, DONE, WAITLOW.
REQ-004 IDLE: on req_i=1, SHALL latch adr_i[31:5] and sel_i.
  - Go to HIT if CACHE_EN, the line is valid and the tag equals adr_i[31:5].
  - Otherwise go to FETCH with beat counter = 0.
REQ-005 HIT: SHALL drive dat_o = buffered line and pulse ack_o, so ack_o is high in the 2nd cycle after req_i is first sampled; then go to WAITLOW.
REQ-006 FETCH: SHALL hold m_cyc_o=m_stb_o=1 continuously across 8 beats, with:
  - m_adr_o = {tag, beat[2:0], 2'b00}
  - m_sel_o = sel[4*beat+3 : 4*beat]
  - m_cti_o = 3'b111 on beat 7, else 3'b010.
REQ-007 On each m_ack_i, SHALL store m_dat_i into dat_o bits [32*beat+31 : 32*beat] and increment beat; the address updates in the next cycle.
REQ-008 Lanes whose 4-bit sel nibble is 0 SHALL still be bus-cycled, and SHALL be stored as 32'h0.
REQ-009 After the beat-7 ack, SHALL drop cyc/stb next cycle, go to DONE, and pulse ack_o in DONE (one cycle after the last m_ack_i).
REQ-010 On m_err_i in FETCH, SHALL:
  - drop cyc/stb next cycle;
  - zero all unfilled lanes;
  - pulse ack_o and err_o together;
  - clear the line-valid flag.
REQ-011 The line SHALL become valid on fill completion only if sel was 32'hFFFFFFFF and no error occurred.
  - Tag = latched address.
  - A partial-sel fill SHALL leave valid=0.
REQ-012 WAITLOW: SHALL stay until req_i=0, then go to IDLE; a held req_i SHALL never produce a second ack_o.
REQ-013 ack_o SHALL be high for exactly one cycle per transaction.
REQ-014 dat_o SHALL stay stable from ack_o until the next fetch's first beat store.
REQ-015 inv_i SHALL clear valid in any state. If inv_i coincides with fill completion, inv_i SHALL win (valid=0); ack_o is unaffected.
REQ-016 Changes to adr_i/sel_i after latching SHALL be ignored until the next IDLE acceptance.
REQ-017 m_ack_i or m_err_i outside FETCH SHALL be ignored.

Reset
REQ-018 rst_i SHALL asynchronously force:
  - state = IDLE
  - ack_o = 0, err_o = 0
  - m_cyc_o = 0, m_stb_o = 0, m_we_o = 0
  - m_cti_o = 0, m_sel_o = 0, m_adr_o = 0
  - dat_o = 0, valid = 0, beat = 0.
REQ-019 Reset during FETCH SHALL abandon the burst immediately with no ack_o; the next request after release refetches.

Structure
REQ-020 gfx256_pkg SHALL hold the state enum, the constant BEATS=8, and the CTI constants (CTI_INCR=3'b010, CTI_EOB=3'b111).
REQ-021 The block SHALL have no sub-module; the line buffer, tag and valid flag are inline registers.

Verification
REQ-022 Full-sel miss:
  - Stimulus: req at adr 32'h0000_1040, sel all ones; slave returns beat k data 32'hA000_0000+k, zero wait.
  - Response: m_adr_o = 1040, 1044 … 105C; cti 010×7 then 111; ack_o one cycle after the 8th m_ack_i; dat_o[31:0]=A0000000, dat_o[255:224]=A0000007.
REQ-023 Hit:
  - Stimulus: repeat the same address after req_i is dropped.
  - Response: no m_cyc_o; ack_o in the 2nd cycle; identical dat_o.
REQ-024 Partial sel:
  - Stimulus: sel=32'h0000_FF0F.
  - Response: beat 1 m_sel_o=0; lane 1 returned 0; a following same-address request misses.
REQ-025 Error:
  - Stimulus: m_err_i on beat 3.
  - Response: cyc drops; ack_o and err_o pulse; lanes 3–7 are 0; the next request misses.
REQ-026 inv_i and held request:
  - Stimulus: inv_i on the last-ack cycle, then a repeat request; separately, hold req_i 5 cycles past ack_o.
  - Response: the repeat refetches; exactly one ack_o while req_i is held.
REQ-027 Reset mid-burst:
  - Stimulus: assert rst_i at beat 4.
  - Response: m_cyc_o=0 asynchronously; no ack_o; the post-reset request fetches all 8 beats.
